// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the round-robin system bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CE_W   = 8;
  localparam int unsigned HB_W   = 2;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [HB_W-1:0]   hb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [CE_W-1:0]   ce;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above ptr, with wrap.
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [IDX_W:0] sum_c;

  assign masked = req & ~excl;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    dbl_c = {masked, masked} >> ptr;
    rot_c = dbl_c[N-1:0];
    sum_c = '0;
    any_c = 1'b0;
    idx_c = '0;
    gnt_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && rot_c[i]) begin
        any_c = 1'b1;
        sum_c = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum_c >= (IDX_W+1)'(N)) sum_c = sum_c - (IDX_W+1)'(N);
        idx_c = sum_c[IDX_W-1:0];
      end
    end
    if (any_c) gnt_c = N'(1) << idx_c;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between NUM_MASTERS requesters,
// with an optional limit on how long an owner may hold the bus while others wait.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [NUM_MASTERS-1:0]        i_M_REQ,
  input  logic [NUM_MASTERS-1:0]        i_M_WE,
  input  logic [HB_W*NUM_MASTERS-1:0]   i_M_HB,
  input  logic [ADDR_W*NUM_MASTERS-1:0] i_M_ADDR,
  input  logic [DATA_W*NUM_MASTERS-1:0] i_M_WDATA,
  input  logic [CE_W*NUM_MASTERS-1:0]   i_M_CE,
  output logic [NUM_MASTERS-1:0]        o_M_GNT,
  output logic [DATA_W-1:0]             o_M_RDATA,
  output logic                          o_S_VALID,
  output logic                          o_S_WE,
  output logic [HB_W-1:0]               o_S_HB,
  output logic [ADDR_W-1:0]             o_S_ADDR,
  output logic [DATA_W-1:0]             o_S_WDATA,
  output logic [CE_W-1:0]               o_S_CE,
  input  logic [DATA_W-1:0]             i_S_RDATA,
  output logic [IDX_W-1:0]              o_OWNER
);

  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] pick_excl;
  logic                   owner_req;
  logic                   hold_hit;
  logic [IDX_W-1:0]       ptr_next;
  bus_req_t               sel;

  // In OWNED every pick is a release or handover, so the owner is always excluded.
  assign pick_excl = (state_q == ARB_OWNED) ? gnt_q : '0;

  bus_arbiter_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (i_M_REQ),
    .ptr   (ptr_q),
    .excl  (pick_excl),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  assign owner_req = |(gnt_q & i_M_REQ);
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(HOLD_LAST));
  assign ptr_next  = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_OWNED;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_OWNED: begin
        if (!owner_req) begin
          ptr_d = ptr_next;
          cnt_d = '0;
          if (pick_any) begin
            gnt_d   = pick_gnt;
            owner_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end else if (hold_hit && pick_any) begin
          ptr_d   = ptr_next;
          cnt_d   = '0;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
        end else if (pick_any) begin
          cnt_d = (cnt_q == CNT_W'(HOLD_LAST)) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Grant-selected payload mux; grant is one-hot so at most one term is taken.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_q[k]) begin
        sel.we    = i_M_WE[k];
        sel.hb    = i_M_HB[k*HB_W +: HB_W];
        sel.addr  = i_M_ADDR[k*ADDR_W +: ADDR_W];
        sel.wdata = i_M_WDATA[k*DATA_W +: DATA_W];
        sel.ce    = i_M_CE[k*CE_W +: CE_W];
      end
    end
  end

  assign o_M_GNT   = gnt_q;
  assign o_OWNER   = owner_q;
  assign o_M_RDATA = i_S_RDATA;
  assign o_S_VALID = owner_req;
  assign o_S_WE    = owner_req & sel.we;
  assign o_S_CE    = owner_req ? sel.ce : '0;
  assign o_S_HB    = sel.hb;
  assign o_S_ADDR  = sel.addr;
  assign o_S_WDATA = sel.wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD=8 instance plus a MAX_HOLD=0 instance).
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req, m_we;
  logic [3:0]  m_hb;
  logic [63:0] m_addr, m_wdata;
  logic [15:0] m_ce;
  logic [31:0] s_rdata;

  logic [1:0]  gnt, gnt0;
  logic [31:0] m_rdata, m_rdata0;
  logic        s_valid, s_valid0, s_we, s_we0;
  logic [1:0]  s_hb, s_hb0, owner, owner0;
  logic [31:0] s_addr, s_addr0, s_wdata, s_wdata0;
  logic [7:0]  s_ce, s_ce0;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(8), .CNT_W(4)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_M_REQ(m_req), .i_M_WE(m_we), .i_M_HB(m_hb),
    .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata), .i_M_CE(m_ce), .o_M_GNT(gnt),
    .o_M_RDATA(m_rdata), .o_S_VALID(s_valid), .o_S_WE(s_we), .o_S_HB(s_hb),
    .o_S_ADDR(s_addr), .o_S_WDATA(s_wdata), .o_S_CE(s_ce), .i_S_RDATA(s_rdata),
    .o_OWNER(owner)
  );

  bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(0), .CNT_W(4)) dut0 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_M_REQ(m_req), .i_M_WE(m_we), .i_M_HB(m_hb),
    .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata), .i_M_CE(m_ce), .o_M_GNT(gnt0),
    .o_M_RDATA(m_rdata0), .o_S_VALID(s_valid0), .o_S_WE(s_we0), .o_S_HB(s_hb0),
    .o_S_ADDR(s_addr0), .o_S_WDATA(s_wdata0), .o_S_CE(s_ce0), .i_S_RDATA(s_rdata),
    .o_OWNER(owner0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_master(input int k, input logic req, input logic we, input logic [1:0] hb,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] ce);
    m_req[k]           = req;
    m_we[k]            = we;
    m_hb[k*2 +: 2]     = hb;
    m_addr[k*32 +: 32] = addr;
    m_wdata[k*32 +: 32] = wdata;
    m_ce[k*8 +: 8]     = ce;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_req = '0; m_we = '0; m_hb = '0; m_addr = '0; m_wdata = '0; m_ce = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    set_master(0, 1'b1, 1'b1, 2'b11, 32'h1000_0000, 32'h1111_1111, 8'h01);
    tick();
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
    total++; if (s_we !== 1'b0 || s_ce !== 8'h00) begin bad++; $display("FAIL reset_we_ce got=%b/%h exp=0/00", s_we, s_ce); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL reset_first_gnt got=%b exp=01", gnt); end
    m_req = '0;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_release got=%b exp=00", gnt); end
  endtask

  task automatic test_single();
    do_reset();
    s_rdata = 32'h1234_5678;
    set_master(1, 1'b1, 1'b1, 2'b10, 32'h2000_0010, 32'hDEAD_BEEF, 8'h02);
    #1;
    total++; if (gnt !== 2'b00 || s_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%b/%b exp=00/0", gnt, s_valid); end
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", gnt); end
    total++; if (owner !== 2'd1) begin bad++; $display("FAIL single_owner got=%0d exp=1", owner); end
    total++; if (s_valid !== 1'b1 || s_we !== 1'b1 || s_hb !== 2'b10) begin bad++; $display("FAIL single_ctl got=%b%b%b exp=1 1 10", s_valid, s_we, s_hb); end
    total++; if (s_addr !== 32'h2000_0010) begin bad++; $display("FAIL single_addr got=%h exp=20000010", s_addr); end
    total++; if (s_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", s_wdata); end
    total++; if (s_ce !== 8'h02) begin bad++; $display("FAIL single_ce got=%h exp=02", s_ce); end
    total++; if (m_rdata !== 32'h1234_5678) begin bad++; $display("FAIL single_rdata got=%h exp=12345678", m_rdata); end
    tick();
    m_req[1] = 1'b0;
    #1;
    total++; if (s_valid !== 1'b0 || s_ce !== 8'h00 || s_we !== 1'b0) begin bad++; $display("FAIL single_gated got=%b/%h/%b exp=0/00/0", s_valid, s_ce, s_we); end
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_release got=%b exp=00", gnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_master(0, 1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 8'h04);
    set_master(1, 1'b1, 1'b1, 2'b00, 32'h0000_0200, 32'h5A5A_5A5A, 8'h08);
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL simul_first got=%b exp=01", gnt); end
    total++; if (s_addr !== 32'h0000_0100 || s_ce !== 8'h04) begin bad++; $display("FAIL simul_m0_bus got=%h/%h exp=00000100/04", s_addr, s_ce); end
    tick();
    m_req[0] = 1'b0;
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL simul_second got=%b exp=10", gnt); end
    total++; if (s_valid !== 1'b1 || s_wdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL simul_m1_bus got=%b/%h exp=1/5a5a5a5a", s_valid, s_wdata); end
    tick();
    m_req[1] = 1'b0;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL simul_idle got=%b exp=00", gnt); end
    m_req = 2'b11;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL simul_ptr_zero got=%b exp=01", gnt); end
    m_req = '0;
    tick();
  endtask

  task automatic test_hold_limit();
    int xfers;
    int cycles;
    do_reset();
    set_master(0, 1'b1, 1'b1, 2'b11, 32'h0000_0300, 32'hAAAA_0000, 8'h01);
    tick();
    tick();
    tick();
    set_master(1, 1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0, 8'h10);
    xfers = 0;
    cycles = 0;
    #1;
    while (gnt !== 2'b10 && cycles < 30) begin
      if (gnt === 2'b01 && s_valid === 1'b1) xfers++;
      tick();
      cycles++;
    end
    total++; if (cycles >= 30) begin bad++; $display("FAIL hold_timeout got=%0d cycles exp<30", cycles); end
    total++; if (xfers != 8) begin bad++; $display("FAIL hold_count got=%0d exp=8", xfers); end
    total++; if (owner !== 2'd1 || s_addr !== 32'h0000_0400) begin bad++; $display("FAIL hold_handover got=%0d/%h exp=1/00000400", owner, s_addr); end
    tick();
    m_req[1] = 1'b0;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL hold_regain got=%b exp=01", gnt); end
    m_req = '0;
    tick();
  endtask

  task automatic test_no_hold();
    int lost;
    do_reset();
    set_master(0, 1'b1, 1'b1, 2'b11, 32'h0000_0300, 32'hAAAA_0000, 8'h01);
    tick();
    tick();
    tick();
    set_master(1, 1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0, 8'h10);
    lost = 0;
    for (int i = 0; i < 14; i++) begin
      if (gnt0 !== 2'b01) lost++;
      tick();
    end
    total++; if (lost != 0) begin bad++; $display("FAIL nohold_keep got=%0d lost cycles exp=0", lost); end
    m_req[0] = 1'b0;
    tick();
    total++; if (gnt0 !== 2'b10) begin bad++; $display("FAIL nohold_handoff got=%b exp=10", gnt0); end
    m_req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_master(0, 1'b1, 1'b0, 2'b01, 32'h0000_0500, 32'h0, 8'h01);
    tick();
    tick();
    m_req[0] = 1'b0;
    set_master(1, 1'b1, 1'b1, 2'b10, 32'h0000_0600, 32'hCAFE_F00D, 8'h20);
    tick();
    total++; if (gnt !== 2'b10 || s_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b exp=10/1", gnt, s_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL arst_gnt got=%b exp=00", gnt); end
    total++; if (s_valid !== 1'b0 || s_we !== 1'b0 || s_ce !== 8'h00) begin bad++; $display("FAIL arst_bus got=%b/%b/%h exp=0/0/00", s_valid, s_we, s_ce); end
    tick();
    m_req = 2'b11;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL arst_ptr got=%b exp=01", gnt); end
    m_req = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    s_rdata = '0;
    m_req = '0; m_we = '0; m_hb = '0; m_addr = '0; m_wdata = '0; m_ce = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_limit();
    test_no_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
